fetch_stage: RTL and testbench

Instruction-fetch stage for the MIPS datapath: holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction and its opcode field to the control decoder and register-file read stage. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled. Taken branches redirect the PC and flush in-flight fetches.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, req/ack instruction-memory port,
// one-entry skid buffer for stalled decode, and branch redirect with drain.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {StIdle, StReq, StSkid, StDrain} fetchStateE;

  fetchStateE  stateQ, stateD;
  logic [31:0] pcQ, pcD;
  logic [31:0] reqAddrQ, reqAddrD;
  logic [31:0] skidInstrQ, skidInstrD;
  logic [31:0] skidPcQ, skidPcD;
  logic        ifValidQ, ifValidD;
  logic [31:0] ifInstrQ, ifInstrD;
  logic [31:0] ifPcQ, ifPcD;

  logic        slotFree;
  logic [31:0] targetAligned;
  logic [31:0] reqAddrPlus4;

  // The output slot can take a new word if it is empty or being consumed now.
  assign slotFree      = !ifValidQ || !stall;
  assign targetAligned = branch_target & ~32'h0000_0003;
  assign reqAddrPlus4  = reqAddrQ + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      pcQ        <= RESET_PC;
      reqAddrQ   <= RESET_PC;
      skidInstrQ <= 32'h0;
      skidPcQ    <= 32'h0;
      ifValidQ   <= 1'b0;
      ifInstrQ   <= 32'h0;
      ifPcQ      <= 32'h0;
    end else begin
      stateQ     <= stateD;
      pcQ        <= pcD;
      reqAddrQ   <= reqAddrD;
      skidInstrQ <= skidInstrD;
      skidPcQ    <= skidPcD;
      ifValidQ   <= ifValidD;
      ifInstrQ   <= ifInstrD;
      ifPcQ      <= ifPcD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    pcD        = pcQ;
    reqAddrD   = reqAddrQ;
    skidInstrD = skidInstrQ;
    skidPcD    = skidPcQ;
    ifValidD   = ifValidQ;
    ifInstrD   = ifInstrQ;
    ifPcD      = ifPcQ;

    if (branch_taken) begin
      pcD      = targetAligned;
      ifValidD = 1'b0;
      case (stateQ)
        StReq: begin
          // An unacknowledged request must finish before the redirect is issued.
          if (imem_ack) begin
            reqAddrD = targetAligned;
          end else begin
            stateD = StDrain;
          end
        end
        StDrain: begin
          if (imem_ack) begin
            reqAddrD = targetAligned;
            stateD   = StReq;
          end
        end
        default: begin
          reqAddrD = targetAligned;
          stateD   = StReq;
        end
      endcase
    end else begin
      case (stateQ)
        StIdle: begin
          reqAddrD = pcQ;
          stateD   = StReq;
        end
        StReq: begin
          if (imem_ack) begin
            pcD = reqAddrPlus4;
            if (slotFree) begin
              ifInstrD = imem_rdata;
              ifPcD    = reqAddrQ;
              ifValidD = 1'b1;
              reqAddrD = reqAddrPlus4;
            end else begin
              skidInstrD = imem_rdata;
              skidPcD    = reqAddrQ;
              stateD     = StSkid;
            end
          end else if (slotFree) begin
            ifValidD = 1'b0;
          end
        end
        StSkid: begin
          if (!stall) begin
            ifInstrD = skidInstrQ;
            ifPcD    = skidPcQ;
            ifValidD = 1'b1;
            reqAddrD = pcQ;
            stateD   = StReq;
          end
        end
        StDrain: begin
          if (imem_ack) begin
            reqAddrD = pcQ;
            stateD   = StReq;
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  assign imem_req    = (stateQ == StReq) || (stateQ == StDrain);
  assign imem_addr   = reqAddrQ;
  assign if_valid    = ifValidQ;
  assign if_instr    = ifInstrQ;
  assign if_pc       = ifPcQ;
  assign if_pc_plus4 = ifPcQ + 32'd4;
  assign opcode      = ifInstrQ[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations and a wrap-around RESET_PC instance.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic [5:0]  opcode;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, plus42;
  logic [5:0]  op2;

  int unsigned lat = 0;
  int unsigned waitCnt = 0;
  logic        ackEn = 1'b1;
  int          nChecks = 0;
  int          nErrors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[7:2], a[25:0]};
  endfunction

  // Memory: acks once the request has waited lat cycles; data is address-tagged.
  assign imem_ack   = imem_req && ackEn && (waitCnt >= lat);
  assign imem_rdata = tag(imem_addr);
  always @(posedge clk) begin
    if (!imem_req || imem_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .opcode(opcode)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(tag(addr2)), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .if_valid(valid2), .if_instr(instr2), .if_pc(pc2),
    .if_pc_plus4(plus42), .opcode(op2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding request, a queue of parked responses, one output slot.
  bit          mInit = 0;
  bit          mJustReset;
  bit          mActive, mDiscard;
  logic [31:0] mPc, mReqAddr;
  logic [31:0] mParked[$];
  bit          mOutValid;
  logic [31:0] mOutPc, mOutInstr;
  logic        sRst, sStall, sBr, sAck;
  logic [31:0] sTgt;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      sRst = rst; sStall = stall; sBr = branch_taken; sTgt = branch_target; sAck = imem_ack;
      @(posedge clk);
      #1;
      if (sRst) begin
        mInit = 1; mJustReset = 1;
        mPc = 32'h0; mReqAddr = 32'h0; mActive = 0; mDiscard = 0;
        mParked.delete();
        mOutValid = 0; mOutPc = 32'h0; mOutInstr = 32'h0;
      end else if (mInit) begin
        mJustReset = 0;
        if (sBr) begin
          mPc = sTgt & ~32'h3;
          mOutValid = 0;
          mParked.delete();
          if (mActive && !sAck) mDiscard = 1;
          else begin mReqAddr = mPc; mActive = 1; mDiscard = 0; end
        end else if (!mActive) begin
          if (mParked.size() == 0) begin
            mActive = 1; mReqAddr = mPc;
          end else if (!sStall) begin
            mOutPc = mParked.pop_front(); mOutInstr = tag(mOutPc); mOutValid = 1;
            mActive = 1; mReqAddr = mPc;
          end
        end else if (sAck) begin
          if (mDiscard) begin
            mDiscard = 0; mReqAddr = mPc;
          end else if (!mOutValid || !sStall) begin
            mOutPc = mReqAddr; mOutInstr = tag(mReqAddr); mOutValid = 1;
            mReqAddr = mReqAddr + 32'd4; mPc = mReqAddr;
          end else begin
            mParked.push_back(mReqAddr); mPc = mReqAddr + 32'd4; mActive = 0;
          end
        end else if (!mOutValid || !sStall) begin
          mOutValid = 0;
        end
      end
      if (mInit) begin
        chk("m_imem_req", 32'(imem_req), 32'(mActive));
        if (mActive) chk("m_imem_addr", imem_addr, mReqAddr);
        chk("m_if_valid", 32'(if_valid), 32'(mOutValid));
        if (mOutValid || mJustReset) begin
          chk("m_if_instr", if_instr, mOutInstr);
          chk("m_if_pc", if_pc, mOutPc);
          chk("m_if_pc_plus4", if_pc_plus4, mOutPc + 32'd4);
          chk("m_opcode", 32'(opcode), 32'(mOutInstr[31:26]));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic relReset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] stallPat;
    stallPat = 16'b0110_0011_1010_0111;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    cyc(1);

    // Zero-wait stream; dut2 checks PC wrap from 0xFFFFFFFC.
    relReset();
    cyc(1);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", 32'(if_valid), 32'd0);
    chk("w_addr0", addr2, 32'hFFFF_FFFC);
    cyc(1);
    chk("t1_pc0", if_pc, 32'h0);
    chk("t1_valid1", 32'(if_valid), 32'd1);
    chk("t1_plus4_0", if_pc_plus4, 32'h4);
    chk("w_pc0", pc2, 32'hFFFF_FFFC);
    chk("w_plus4", plus42, 32'h0);
    chk("w_op", 32'(op2), 32'h3F);
    chk("w_addr1", addr2, 32'h0);
    cyc(1);
    chk("t1_pc4", if_pc, 32'h4);
    chk("t1_instr4", if_instr, 32'h0400_0004);
    chk("t1_op4", 32'(opcode), 32'd1);
    chk("w_pc1", pc2, 32'h0);
    cyc(1);
    chk("t1_pc8", if_pc, 32'h8);
    chk("t1_op8", 32'(opcode), 32'd2);
    cyc(1);
    chk("t1_pcC", if_pc, 32'hC);
    chk("t1_instrC", if_instr, 32'h0C00_000C);

    // Three-cycle ack latency.
    lat = 2;
    relReset();
    cyc(1); chk("t2_addr_a", imem_addr, 32'h0); chk("t2_req", 32'(imem_req), 32'd1);
    cyc(1); chk("t2_addr_b", imem_addr, 32'h0); chk("t2_nv_b", 32'(if_valid), 32'd0);
    cyc(1); chk("t2_addr_c", imem_addr, 32'h0);
    cyc(1); chk("t2_v0", 32'(if_valid), 32'd1); chk("t2_pc0", if_pc, 32'h0);
    chk("t2_addr4", imem_addr, 32'h4);
    cyc(1); chk("t2_nv_d", 32'(if_valid), 32'd0); chk("t2_addr4b", imem_addr, 32'h4);
    cyc(1); chk("t2_nv_e", 32'(if_valid), 32'd0);
    cyc(1); chk("t2_v4", 32'(if_valid), 32'd1); chk("t2_pc4", if_pc, 32'h4);
    cyc(6);
    lat = 0;

    // Stall while 0x8 is acked: skid, then release.
    relReset();
    cyc(3);
    stall = 1'b1;
    cyc(1);
    chk("t3_req_off", 32'(imem_req), 32'd0);
    chk("t3_hold_pc", if_pc, 32'h4);
    chk("t3_hold_instr", if_instr, 32'h0400_0004);
    cyc(3);
    chk("t3_req_off2", 32'(imem_req), 32'd0);
    chk("t3_hold_pc2", if_pc, 32'h4);
    stall = 1'b0;
    cyc(1);
    chk("t3_pc8", if_pc, 32'h8);
    chk("t3_instr8", if_instr, 32'h0800_0008);
    chk("t3_addrC", imem_addr, 32'hC);
    cyc(1);
    chk("t3_pcC", if_pc, 32'hC);

    // Branch to 0x40 with 0x10 outstanding.
    relReset();
    cyc(5);
    ackEn = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    cyc(1);
    branch_taken = 1'b0;
    chk("t4_nv", 32'(if_valid), 32'd0);
    chk("t4_drain_addr", imem_addr, 32'h10);
    cyc(1);
    chk("t4_drain_addr2", imem_addr, 32'h10);
    ackEn = 1'b1;
    cyc(1);
    chk("t4_nv2", 32'(if_valid), 32'd0);
    chk("t4_addr40", imem_addr, 32'h40);
    cyc(1);
    chk("t4_pc40", if_pc, 32'h40);
    chk("t4_instr40", if_instr, 32'h4000_0040);
    chk("t4_op40", 32'(opcode), 32'h10);

    // Branch coincident with ack under stall; unaligned target.
    relReset();
    cyc(3);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h43;
    cyc(1);
    stall = 1'b0; branch_taken = 1'b0;
    chk("t5_nv", 32'(if_valid), 32'd0);
    chk("t5_addr40", imem_addr, 32'h40);
    cyc(1);
    chk("t5_pc40", if_pc, 32'h40);

    // Reset asserted mid-drain.
    relReset();
    cyc(5);
    ackEn = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    cyc(1);
    branch_taken = 1'b0; rst = 1'b1;
    cyc(1);
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", 32'(if_valid), 32'd0);
    chk("t6_instr", if_instr, 32'h0);
    chk("t6_plus4", if_pc_plus4, 32'h4);
    ackEn = 1'b1;

    // Mixed stall pattern with two-cycle latency, model-checked.
    lat = 1;
    relReset();
    for (int i = 0; i < 16; i++) begin
      stall = stallPat[i];
      cyc(1);
    end
    stall = 1'b0;
    cyc(6);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
